// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// word_t and regbits_t match the CPU-wide definitions for data words and register indices.
package regfile_wb_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // Largest supported number of writeback requesters
    localparam int unsigned WB_NREQ_MAX = 4;

    // One writeback request as presented by a source
    typedef struct packed {
        logic     req;
        regbits_t wsel;
        word_t    wdat;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first asserted request at or after ptr.
// Purely combinational so it can be reused wherever a rotating priority pick is needed.
module regfile_wb_arbiter_rr_arbiter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0] mask_ge;
    logic [N-1:0] req_hi;

    // Prefer requests at or above ptr; fall back to the lowest request to wrap around
    always_comb begin
        mask_ge = ~((N'(1) << ptr) - N'(1));
        req_hi  = req & mask_ge;
        if (|req_hi) begin
            gnt = req_hi & (~req_hi + N'(1));
        end else begin
            gnt = req & (~req + N'(1));
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between N_REQ writeback sources.
// Round-robin grant, one-cycle registered write stage, halt freeze, saturating conflict count.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ = 2,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [N_REQ-1:0]     req,
    input  regbits_t             req_wsel [N_REQ],
    input  word_t                req_wdat [N_REQ],
    output logic [N_REQ-1:0]     gnt,
    input  logic                 halt,
    output logic                 rf_WEN,
    output regbits_t             rf_wsel,
    output word_t                rf_wdat,
    output logic [CNT_W-1:0]     conflict_cnt
);

    wb_req_t           reqs [N_REQ];
    logic [N_REQ-1:0]  req_en;
    logic              arb_en;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wen_q, wen_d;
    regbits_t          wsel_q, wsel_d;
    word_t             wdat_q, wdat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    wb_req_t           win;
    logic [PTR_W-1:0]  gnt_idx;
    logic              any_gnt;

    // Bundle per-requester inputs and gate requests off during halt or reset
    always_comb begin
        arb_en = nRST & ~halt;
        for (int i = 0; i < N_REQ; i++) begin
            reqs[i] = '{req: req[i], wsel: req_wsel[i], wdat: req_wdat[i]};
            req_en[i] = reqs[i].req & arb_en;
        end
    end

    regfile_wb_arbiter_rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req (req_en),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Encode the one-hot grant and select the winning request
    always_comb begin
        win     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win     = reqs[i];
                gnt_idx = PTR_W'(i);
                any_gnt = 1'b1;
            end
        end
    end

    // Next state: load winning write, rotate priority, count contended grants
    always_comb begin
        ptr_d  = ptr_q;
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        cnt_d  = cnt_q;
        if (any_gnt) begin
            wsel_d = win.wsel;
            wdat_d = win.wdat;
            // Writes to r0 are consumed but never issued
            wen_d  = |win.wsel;
            ptr_d  = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            if (($countones(req) >= 2) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr_q  <= '0;
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            wsel_q <= wsel_d;
            wdat_q <= wdat_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rf_WEN       = wen_q;
    assign rf_wsel      = wsel_q;
    assign rf_wdat      = wdat_q;
    assign conflict_cnt = cnt_q;

endmodule
